time_set_controller: RTL

//   Synchronous front-end controller for the clock-face datapath. Conditions the two raw

---
 rtl/clock_ctrl_pkg.sv | 5 +
 rtl/button_conditioner.sv | 38 +++
 rtl/time_set_controller.sv | 94 +++++++++
 3 files changed

// File: rtl/clock_ctrl_pkg.sv
// clock_ctrl_pkg: shared mode encoding for the clock-face controller
package clock_ctrl_pkg;
  localparam int MODE_W = 2;
  typedef enum logic [MODE_W-1:0] {MODE_RUN, MODE_SET_SECS, MODE_SET_MINS, MODE_SET_HOURS} mode_t;
endpackage

// File: rtl/button_conditioner.sv
// button_conditioner: 2-flop synchronizer, debounce counter and registered rising-edge press pulse
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d, prev_q, press_q, differ, flip;
  always_comb begin
    differ = sync_q[1] != level_q;
    flip = differ && cnt_q == CW'(DEBOUNCE_CYCLES - 1);
    cnt_d = (differ && !flip) ? cnt_q + CW'(1) : '0;
    level_d = level_q ^ flip;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
      cnt_q <= '0;
      level_q <= 1'b0;
      prev_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      cnt_q <= cnt_d;
      level_q <= level_d;
      prev_q <= level_q;
      press_q <= level_q & ~prev_q;
    end
  end
  assign level_o = level_q;
  assign press_o = press_q;
endmodule

// File: rtl/time_set_controller.sv
// time_set_controller: button conditioning, time-set mode FSM, timeout and increment strobes.
// Define TSC_AUTOREPEAT_EN to build the held-inc auto-repeat logic.
module time_set_controller
  import clock_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_SECS = 10
`ifdef TSC_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_PERIOD = 4
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_1hz,
  input  logic              btn_mode,
  input  logic              btn_inc,
  output logic [MODE_W-1:0] mode,
  output logic              inc_secs,
  output logic              inc_mins,
  output logic              inc_hours,
  output logic              run_en,
  output logic              mode_led
);
  localparam int TW = $clog2(TIMEOUT_SECS + 1);
  mode_t mode_q, mode_d;
  logic [2:0] inc_q, inc_d;
  logic run_en_q, run_en_d, led_q, led_d;
  logic [TW-1:0] to_q, to_d;
  logic mode_press, inc_press_raw, inc_level, mode_level_unused;
  logic set, inc_press, rep_fire, strobe, timeout;
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk(clk), .reset(reset), .btn_i(btn_mode), .level_o(mode_level_unused), .press_o(mode_press)
  );
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clk(clk), .reset(reset), .btn_i(btn_inc), .level_o(inc_level), .press_o(inc_press_raw)
  );
`ifdef TSC_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY);
  logic [RW-1:0] rep_q, rep_d;
  logic rep_act_q, rep_act_d;
  // after a fire, reload so the next fire lands REPEAT_PERIOD cycles later
  always_comb begin
    rep_fire = rep_act_q & inc_level & set & ~mode_press & (rep_q == RW'(REPEAT_DELAY - 1));
    rep_act_d = inc_press | (rep_act_q & inc_level & set & ~mode_press & ~timeout);
    rep_d = inc_press ? '0 : rep_fire ? RW'(REPEAT_DELAY - REPEAT_PERIOD) : rep_act_q ? rep_q + RW'(1) : rep_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      rep_q <= '0;
      rep_act_q <= 1'b0;
    end else begin
      rep_q <= rep_d;
      rep_act_q <= rep_act_d;
    end
  end
`else
  logic unused_inc_level;
  assign rep_fire = 1'b0;
  assign unused_inc_level = inc_level;
`endif
  // mode press beats inc press; any press beats a coincident tick
  always_comb begin
    set = mode_q != MODE_RUN;
    inc_press = inc_press_raw & set & ~mode_press;
    strobe = inc_press | rep_fire;
    timeout = set & tick_1hz & ~mode_press & ~strobe & (to_q == TW'(TIMEOUT_SECS - 1));
    mode_d = mode_press ? mode_t'(mode_q + 2'd1) : timeout ? MODE_RUN : mode_q;
    to_d = (!set || mode_press || strobe || timeout) ? '0 : to_q + TW'(tick_1hz);
    inc_d = strobe ? {mode_q == MODE_SET_HOURS, mode_q == MODE_SET_MINS, mode_q == MODE_SET_SECS} : 3'b000;
    run_en_d = mode_d == MODE_RUN;
    led_d = (mode_d == MODE_RUN) ? 1'b0 : (mode_d != mode_q) ? 1'b1 : led_q ^ tick_1hz;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_q <= MODE_RUN;
      inc_q <= 3'b000;
      run_en_q <= 1'b1;
      led_q <= 1'b0;
      to_q <= '0;
    end else begin
      mode_q <= mode_d;
      inc_q <= inc_d;
      run_en_q <= run_en_d;
      led_q <= led_d;
      to_q <= to_d;
    end
  end
  assign mode = mode_q;
  assign {inc_hours, inc_mins, inc_secs} = inc_q;
  assign run_en = run_en_q;
  assign mode_led = led_q;
endmodule
